// File: rtl/tile_local_port_pkg.sv
// Shared types for the tile local port: tile ids, transactions, fabric ready bits and XY routing.
package tile_local_port_pkg;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } t_tile_id;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
  } t_tile_trans;

  typedef logic [3:0] t_fab_ready;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  typedef enum logic [2:0] {N = 3'd0, E = 3'd1, S = 3'd2, W = 3'd3, LOOPBACK = 3'd4} t_dir;

  // X is resolved before Y so routes stay deadlock-free on the mesh.
  function automatic t_dir f_xy_dir(input t_tile_id cur, input t_tile_id dst);
    t_dir d;
    if (dst.x > cur.x)      d = E;
    else if (dst.x < cur.x) d = W;
    else if (dst.y > cur.y) d = N;
    else if (dst.y < cur.y) d = S;
    else                    d = LOOPBACK;
    return d;
  endfunction

endpackage

// File: rtl/tile_local_port_fifo.sv
// Small synchronous FIFO with combinational head; pointers carry an extra wrap bit for full/empty.
module tile_local_port_fifo
  import tile_local_port_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  T            push_data,
  input  logic        pop,
  output T            head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] free
);

  logic [AW:0] r_wr, r_rd;
  T            r_mem [DEPTH];
  logic        w_pop, w_push;

  assign empty  = (r_wr == r_rd);
  assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign free   = (AW+1)'(DEPTH) - (r_wr - r_rd);
  assign head   = r_mem[r_rd[AW-1:0]];
  assign w_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tile_local_port.sv
// Tile local endpoint: round-robin core merge into TX, XY dispatch to the router, RX with skid reserve.
module tile_local_port
  import tile_local_port_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int RX_SKID  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  t_tile_id                 local_tile_id,
  input  logic        [NUM_CH-1:0] core_req_valid,
  input  t_tile_trans [NUM_CH-1:0] core_req,
  output logic        [NUM_CH-1:0] core_req_ready,
  output logic                     core_rsp_valid,
  output t_tile_trans              core_rsp,
  input  logic                     core_rsp_ready,
  output logic                     fab_out_valid,
  output t_tile_trans              fab_out_req,
  input  t_fab_ready               fab_out_ready,
  input  logic                     fab_in_valid,
  input  t_tile_trans              fab_in_req,
  output t_fab_ready               fab_in_ready,
  output logic        [CNT_W-1:0]  tx_cnt,
  output logic        [CNT_W-1:0]  rx_cnt,
  output logic        [CNT_W-1:0]  lb_cnt,
  output logic                     rx_ovf
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TXF_W = $clog2(TX_DEPTH) + 1;
  localparam int RXF_W = $clog2(RX_DEPTH) + 1;

  logic [CH_W-1:0]   r_ptr, w_win;
  logic [NUM_CH-1:0] w_grant;
  logic              w_any, w_accept;
  t_tile_trans       w_tx_head, w_rx_head, w_rx_data;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [TXF_W-1:0]  w_tx_free;
  logic [RXF_W-1:0]  w_rx_free, w_rx_free_nxt;
  t_dir              w_dir;
  logic              w_dir_rdy, w_send, w_lb, w_rx_pop, w_rx_fab, w_rx_push, w_drop;
  logic              w_unused;
  t_fab_ready        r_fab_in_ready;
  logic [CNT_W-1:0]  r_tx_cnt, r_rx_cnt, r_lb_cnt;
  logic              r_rx_ovf;

  always_comb begin
    w_any   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_any && core_req_valid[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
    if (w_any) w_grant[w_win] = 1'b1;
  end

  assign core_req_ready = w_grant & {NUM_CH{~w_tx_full}};
  assign w_accept       = w_any & ~w_tx_full;

  tile_local_port_fifo #(.T(t_tile_trans), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst), .push(w_accept), .push_data(core_req[w_win]), .pop(w_send | w_lb),
    .head(w_tx_head), .full(w_tx_full), .empty(w_tx_empty), .free(w_tx_free)
  );

  assign w_unused = ^w_tx_free;
  assign w_dir    = f_xy_dir(local_tile_id, t_tile_id'(w_tx_head.address[31:24]));

  always_comb begin
    w_dir_rdy = 1'b0;
    case (w_dir)
      N:       w_dir_rdy = fab_out_ready[DIR_N];
      E:       w_dir_rdy = fab_out_ready[DIR_E];
      S:       w_dir_rdy = fab_out_ready[DIR_S];
      W:       w_dir_rdy = fab_out_ready[DIR_W];
      default: w_dir_rdy = 1'b0;
    endcase
  end

  assign fab_out_valid = ~w_tx_empty & (w_dir != LOOPBACK);
  assign fab_out_req   = w_tx_head;
  assign w_send        = fab_out_valid & w_dir_rdy;
  // Fabric deliveries own the RX write port; loopback only slips into idle cycles.
  assign w_lb          = ~w_tx_empty & (w_dir == LOOPBACK) & ~fab_in_valid & ~w_rx_full;

  assign w_rx_pop      = core_rsp_ready & ~w_rx_empty;
  assign w_rx_fab      = fab_in_valid & (~w_rx_full | w_rx_pop);
  assign w_drop        = fab_in_valid & ~w_rx_fab;
  assign w_rx_push     = w_rx_fab | w_lb;
  assign w_rx_data     = fab_in_valid ? fab_in_req : w_tx_head;
  assign w_rx_free_nxt = w_rx_free + RXF_W'(w_rx_pop) - RXF_W'(w_rx_push);

  tile_local_port_fifo #(.T(t_tile_trans), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst), .push(w_rx_push), .push_data(w_rx_data), .pop(w_rx_pop),
    .head(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .free(w_rx_free)
  );

  assign core_rsp_valid = ~w_rx_empty;
  assign core_rsp       = w_rx_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr          <= '0;
      r_fab_in_ready <= '0;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_lb_cnt       <= '0;
      r_rx_ovf       <= 1'b0;
    end else begin
      if (w_accept) r_ptr <= (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
      // Keep RX_SKID slots spare for pushes the router already has in flight.
      r_fab_in_ready <= {4{w_rx_free_nxt > RXF_W'(RX_SKID)}};
      if (w_send   && r_tx_cnt != '1) r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_rx_fab && r_rx_cnt != '1) r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_lb     && r_lb_cnt != '1) r_lb_cnt <= r_lb_cnt + 1'b1;
      if (w_drop) r_rx_ovf <= 1'b1;
    end
  end

  assign fab_in_ready = r_fab_in_ready;
  assign tx_cnt       = r_tx_cnt;
  assign rx_cnt       = r_rx_cnt;
  assign lb_cnt       = r_lb_cnt;
  assign rx_ovf       = r_rx_ovf;

endmodule

// File: tb/tb_tile_local_port.sv
// Directed scenarios plus a randomized run against a queue-based model of the tile local port.
module tb_tile_local_port;
  import tile_local_port_pkg::*;

  localparam int NUM_CH = 2, TXD = 4, RXD = 4, SKID = 2, CNT_W = 16;
  localparam int LX = 1, LY = 1;

  logic                     clk, rst;
  t_tile_id                 local_tile_id;
  logic        [NUM_CH-1:0] core_req_valid, core_req_ready;
  t_tile_trans [NUM_CH-1:0] core_req;
  logic                     core_rsp_valid, core_rsp_ready;
  t_tile_trans              core_rsp, fab_out_req, fab_in_req;
  logic                     fab_out_valid, fab_in_valid, rx_ovf;
  t_fab_ready               fab_out_ready, fab_in_ready;
  logic        [CNT_W-1:0]  tx_cnt, rx_cnt, lb_cnt;

  int c_total, c_pass;

  tile_local_port #(.NUM_CH(NUM_CH), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_SKID(SKID), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .local_tile_id(local_tile_id),
    .core_req_valid(core_req_valid), .core_req(core_req), .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp(core_rsp), .core_rsp_ready(core_rsp_ready),
    .fab_out_valid(fab_out_valid), .fab_out_req(fab_out_req), .fab_out_ready(fab_out_ready),
    .fab_in_valid(fab_in_valid), .fab_in_req(fab_in_req), .fab_in_ready(fab_in_ready),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .lb_cnt(lb_cnt), .rx_ovf(rx_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic t_tile_trans mk(input logic [7:0] dst, input logic [31:0] d);
    t_tile_trans t;
    t.address = {dst, d[23:0]};
    t.data    = d;
    return t;
  endfunction

  // 0=N 1=E 2=S 3=W 4=self, X before Y
  function automatic int m_dir(input logic [7:0] dst);
    int dx, dy;
    dx = int'(dst[7:4]);
    dy = int'(dst[3:0]);
    if (dx > LX) return 1;
    if (dx < LX) return 3;
    if (dy > LY) return 0;
    if (dy < LY) return 2;
    return 4;
  endfunction

  task automatic idle();
    core_req_valid = '0;
    core_req       = '0;
    core_rsp_ready = 1'b0;
    fab_out_ready  = '0;
    fab_in_valid   = 1'b0;
    fab_in_req     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    c_total++; if (fab_in_ready !== 4'b0000) $display("FAIL reset_fab_in_ready got %b want 0000", fab_in_ready); else c_pass++;
    c_total++; if ({fab_out_valid, core_rsp_valid} !== 2'b00) $display("FAIL reset_valids got %b want 00", {fab_out_valid, core_rsp_valid}); else c_pass++;
    rst = 1'b1;
    tick();
    c_total++; if (fab_in_ready !== 4'b1111) $display("FAIL release_fab_in_ready got %b want 1111", fab_in_ready); else c_pass++;
    c_total++; if ({tx_cnt, rx_cnt, lb_cnt} !== '0 || rx_ovf !== 1'b0) $display("FAIL release_counters got %0d/%0d/%0d ovf %b want 0", tx_cnt, rx_cnt, lb_cnt, rx_ovf); else c_pass++;
  endtask

  task automatic test_rr();
    logic [1:0] exp;
    fab_out_ready  = 4'hF;
    core_req_valid = 2'b11;
    core_req[0]    = mk(8'h21, 32'hA0);
    core_req[1]    = mk(8'h21, 32'hB0);
    for (int k = 0; k < 6; k++) begin
      #3;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      c_total++; if (core_req_ready !== exp) $display("FAIL rr_grant k=%0d got %b want %b", k, core_req_ready, exp); else c_pass++;
      if (k > 0) begin
        c_total++;
        if (fab_out_valid !== 1'b1 || fab_out_req.data !== ((k % 2 == 1) ? 32'hA0 : 32'hB0))
          $display("FAIL rr_out k=%0d got v=%b d=%h", k, fab_out_valid, fab_out_req.data);
        else c_pass++;
      end
      tick();
    end
    core_req_valid = '0;
    tick();
    c_total++; if (tx_cnt !== 16'd6) $display("FAIL rr_tx_cnt got %0d want 6", tx_cnt); else c_pass++;
    c_total++; if (fab_out_valid !== 1'b0) $display("FAIL rr_drain got %b want 0", fab_out_valid); else c_pass++;
  endtask

  task automatic send_blocked(input logic [7:0] dst, input logic [31:0] d, input t_fab_ready blk,
                              input t_fab_ready go, input int exp_tx);
    core_req_valid = 2'b01;
    core_req[0]    = mk(dst, d);
    fab_out_ready  = blk;
    tick();
    core_req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #3;
      c_total++;
      if (fab_out_valid !== 1'b1 || fab_out_req !== mk(dst, d))
        $display("FAIL xy_hold dst=%h k=%0d got v=%b req=%h", dst, k, fab_out_valid, fab_out_req);
      else c_pass++;
      tick();
    end
    c_total++; if (tx_cnt !== CNT_W'(exp_tx - 1)) $display("FAIL xy_held_cnt dst=%h got %0d want %0d", dst, tx_cnt, exp_tx - 1); else c_pass++;
    fab_out_ready = go;
    tick();
    c_total++; if (tx_cnt !== CNT_W'(exp_tx) || fab_out_valid !== 1'b0) $display("FAIL xy_sent dst=%h got cnt %0d v=%b want %0d", dst, tx_cnt, fab_out_valid, exp_tx); else c_pass++;
    fab_out_ready = '0;
  endtask

  task automatic test_xy();
    send_blocked(8'h30, 32'hC0, 4'b1101, 4'b0010, 7);
    send_blocked(8'h13, 32'hD0, 4'b1110, 4'b0001, 8);
  endtask

  task automatic test_rx_skid();
    core_rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      fab_in_valid = 1'b1;
      fab_in_req   = mk(8'h11, 32'hE0 + 32'(i));
      tick();
      c_total++; if (fab_in_ready !== ((i == 1) ? 4'b1111 : 4'b0000)) $display("FAIL skid_ready push=%0d got %b", i, fab_in_ready); else c_pass++;
      c_total++; if (rx_ovf !== (i == 5)) $display("FAIL skid_ovf push=%0d got %b", i, rx_ovf); else c_pass++;
      c_total++; if (rx_cnt !== CNT_W'((i < 4) ? i : 4)) $display("FAIL skid_rx_cnt push=%0d got %0d", i, rx_cnt); else c_pass++;
    end
    fab_in_valid   = 1'b0;
    core_rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #3;
      c_total++;
      if (core_rsp_valid !== 1'b1 || core_rsp.data !== 32'hE0 + 32'(i))
        $display("FAIL skid_drain i=%0d got v=%b d=%h want %h", i, core_rsp_valid, core_rsp.data, 32'hE0 + 32'(i));
      else c_pass++;
      tick();
    end
    core_rsp_ready = 1'b0;
    c_total++; if (core_rsp_valid !== 1'b0 || fab_in_ready !== 4'b1111) $display("FAIL skid_empty got v=%b rdy=%b", core_rsp_valid, fab_in_ready); else c_pass++;
  endtask

  task automatic test_loopback();
    logic [31:0] exp_d [4];
    exp_d = '{32'hF0, 32'hF1, 32'hF2, 32'h1B};
    core_req_valid = 2'b01;
    core_req[0]    = mk(8'h11, 32'h1B);
    tick();
    core_req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      fab_in_valid = 1'b1;
      fab_in_req   = mk(8'h11, 32'hF0 + 32'(j));
      #3;
      c_total++; if (fab_out_valid !== 1'b0) $display("FAIL lb_no_fab_out j=%0d got %b", j, fab_out_valid); else c_pass++;
      tick();
      c_total++; if (lb_cnt !== 16'd0) $display("FAIL lb_yield j=%0d got %0d want 0", j, lb_cnt); else c_pass++;
    end
    fab_in_valid = 1'b0;
    tick();
    c_total++; if (lb_cnt !== 16'd1 || rx_cnt !== 16'd7) $display("FAIL lb_done got lb %0d rx %0d want 1/7", lb_cnt, rx_cnt); else c_pass++;
    core_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      c_total++;
      if (core_rsp_valid !== 1'b1 || core_rsp.data !== exp_d[i])
        $display("FAIL lb_order i=%0d got v=%b d=%h want %h", i, core_rsp_valid, core_rsp.data, exp_d[i]);
      else c_pass++;
      tick();
    end
    core_rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    fab_out_ready  = '0;
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_req_valid = 2'b01;
      core_req[0]    = mk(8'h21, 32'h50 + 32'(i));
      fab_in_valid   = (i < 2);
      fab_in_req     = mk(8'h11, 32'h60 + 32'(i));
      tick();
    end
    idle();
    #1;
    c_total++; if ({fab_out_valid, core_rsp_valid} !== 2'b11) $display("FAIL mid_loaded got %b want 11", {fab_out_valid, core_rsp_valid}); else c_pass++;
    rst = 1'b0;
    #1;
    c_total++; if ({fab_out_valid, core_rsp_valid} !== 2'b00 || fab_in_ready !== 4'b0000) $display("FAIL mid_async got v=%b rdy=%b", {fab_out_valid, core_rsp_valid}, fab_in_ready); else c_pass++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    c_total++; if ({fab_out_valid, core_rsp_valid} !== 2'b00 || fab_in_ready !== 4'b1111) $display("FAIL mid_release got v=%b rdy=%b", {fab_out_valid, core_rsp_valid}, fab_in_ready); else c_pass++;
    c_total++; if ({tx_cnt, rx_cnt, lb_cnt} !== '0 || rx_ovf !== 1'b0) $display("FAIL mid_counters got %0d/%0d/%0d ovf %b", tx_cnt, rx_cnt, lb_cnt, rx_ovf); else c_pass++;
  endtask

  task automatic test_random();
    t_tile_trans txq[$], rxq[$];
    logic [7:0]  dsts [6];
    int          m_ptr, m_tx, m_rx, m_lb, win, hd;
    bit          m_ready, m_ovf, exp_fov, send, lb, rpop, fab_ok;
    logic [1:0]  exp_rdy;
    dsts    = '{8'h11, 8'h21, 8'h01, 8'h12, 8'h10, 8'h33};
    m_ptr   = 0; m_tx = 0; m_rx = 0; m_lb = 0;
    m_ready = 1'b1; m_ovf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      core_req_valid = 2'($urandom_range(0, 3));
      for (int c = 0; c < NUM_CH; c++) core_req[c] = mk(dsts[$urandom_range(0, 5)], $urandom);
      fab_out_ready  = 4'($urandom_range(0, 15));
      fab_in_valid   = m_ready && ($urandom_range(0, 2) != 0);
      fab_in_req     = mk(8'h11, $urandom);
      core_rsp_ready = ($urandom_range(0, 2) == 0);

      win = -1; exp_rdy = '0;
      if (txq.size() < TXD)
        for (int k = 0; k < NUM_CH; k++)
          if (win < 0 && core_req_valid[(m_ptr + k) % NUM_CH]) win = (m_ptr + k) % NUM_CH;
      if (win >= 0) exp_rdy[win] = 1'b1;
      hd      = (txq.size() > 0) ? m_dir(txq[0].address[31:24]) : 4;
      exp_fov = (txq.size() > 0) && (hd != 4);

      #3;
      c_total++; if (core_req_ready !== exp_rdy) $display("FAIL rnd_req_ready cyc=%0d got %b want %b", cyc, core_req_ready, exp_rdy); else c_pass++;
      c_total++; if (fab_out_valid !== exp_fov) $display("FAIL rnd_fab_out_valid cyc=%0d got %b want %b", cyc, fab_out_valid, exp_fov); else c_pass++;
      if (exp_fov) begin
        c_total++; if (fab_out_req !== txq[0]) $display("FAIL rnd_fab_out_req cyc=%0d got %h want %h", cyc, fab_out_req, txq[0]); else c_pass++;
      end
      c_total++; if (core_rsp_valid !== (rxq.size() > 0)) $display("FAIL rnd_rsp_valid cyc=%0d got %b want %b", cyc, core_rsp_valid, rxq.size() > 0); else c_pass++;
      if (rxq.size() > 0) begin
        c_total++; if (core_rsp !== rxq[0]) $display("FAIL rnd_rsp cyc=%0d got %h want %h", cyc, core_rsp, rxq[0]); else c_pass++;
      end
      c_total++; if (fab_in_ready !== {4{m_ready}}) $display("FAIL rnd_fab_in_ready cyc=%0d got %b want %b", cyc, fab_in_ready, {4{m_ready}}); else c_pass++;
      c_total++;
      if (tx_cnt !== CNT_W'(m_tx) || rx_cnt !== CNT_W'(m_rx) || lb_cnt !== CNT_W'(m_lb) || rx_ovf !== m_ovf)
        $display("FAIL rnd_counters cyc=%0d got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b", cyc, tx_cnt, rx_cnt, lb_cnt, rx_ovf, m_tx, m_rx, m_lb, m_ovf);
      else c_pass++;

      send   = exp_fov && fab_out_ready[hd];
      lb     = (txq.size() > 0) && (hd == 4) && !fab_in_valid && (rxq.size() < RXD);
      rpop   = core_rsp_ready && (rxq.size() > 0);
      fab_ok = fab_in_valid && ((rxq.size() < RXD) || rpop);
      if (rpop) void'(rxq.pop_front());
      if (fab_ok) begin rxq.push_back(fab_in_req); m_rx++; end
      else if (fab_in_valid) m_ovf = 1'b1;
      if (lb) begin rxq.push_back(txq[0]); m_lb++; end
      if (send) m_tx++;
      if (send || lb) void'(txq.pop_front());
      if (win >= 0) begin
        txq.push_back(core_req[win]);
        m_ptr = (win + 1) % NUM_CH;
      end
      m_ready = (RXD - rxq.size()) > SKID;
      tick();
    end
    idle();
  endtask

  initial begin
    c_total       = 0;
    c_pass        = 0;
    local_tile_id = '{x: 4'd1, y: 4'd1};
    test_reset();
    test_rr();
    test_xy();
    test_rx_skid();
    test_loopback();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", c_pass, c_total);
    $finish;
  end

endmodule
